bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master to one-slave arbiter for the CPU's 32-bit stb/ack memory bus.
- Lets the CPU (m0) share the RAM / LED bank decode with a second master (m1), such as a video fetch or DMA engine.
- Sits between the masters and the top-level bank decode. It grants one transaction at a time, round-robin by default, and routes ack and read data back to the granted master only.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin on ties; 1 = m0 always wins ties.
- TIMEOUT_CYCLES, 255, wait-cycle limit before a forced completion. Used only with BUS_TIMEOUT_EN. Legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- m0_stb_i, m1_stb_i  in  1  request strobe; held with stable adr/we/sel/dat until ack
- m0_we_i, m1_we_i  in  1  write enable
- m0_adr_i, m1_adr_i  in  32  byte address
- m0_dat_i, m1_dat_i  in  32  write data
- m0_sel_i, m1_sel_i  in  4  byte lane selects
- m0_ack_o, m1_ack_o  out  1  transfer complete
- m0_dat_o, m1_dat_o  out  32  read data, valid when ack is high
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_sel_o  out  4  slave byte lane selects
- s_ack_i  in  1  slave ack; zero or more wait cycles
- s_dat_i  in  32  slave read data, valid with s_ack_i
- gnt_o  out  2  one-hot current grant; 00 when idle
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_ni low, takes effect immediately, no clock needed):
  - state=IDLE, last_gnt=m1 (so m0 wins the first tie).
  - All outputs 0: s_*, m*_ack_o, m*_dat_o, gnt_o, timeout_o. Any in-flight transfer is abandoned with no ack.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - s_stb_o=0. Both acks 0.
  - At the clock edge, sample the strobes:
    - only m0 requesting -> GNT0; only m1 requesting -> GNT1.
    - both requesting, FIXED_PRIO=0 -> grant the master that is not last_gnt.
    - both requesting, FIXED_PRIO=1 -> GNT0.
    - neither -> stay in IDLE.
- GNTx:
  - s_we/adr/dat/sel_o driven combinationally from master x; s_stb_o = mx_stb_i.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i when s_ack_i is high, else 0.
  - The other master sees ack=0 and dat=0, and its s_* fields are never driven.
  - s_ack_i high -> IDLE next edge, last_gnt<=x.
  - mx_stb_i low before ack (abort) -> IDLE next edge, last_gnt<=x. An s_ack_i arriving in that cycle is discarded.
- s_ack_i while in IDLE: ignored, no ack forwarded.
- Latency:
  - Request seen at edge N -> s_stb_o high in cycle N+1.
  - Zero-wait slave acks in cycle N+1.
  - Mandatory IDLE bubble after each transfer -> at most 1 transfer per 2 cycles.
- Masters need not drop stb after ack. A still-high stb in IDLE is treated as a new request.
- gnt_o: 01 in GNT0, 10 in GNT1, 00 in IDLE. Registered state decode.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter, cleared in IDLE; increments each GNTx cycle with s_stb_o=1 and s_ack_i=0.
  - When count == TIMEOUT_CYCLES-1 and s_ack_i=0:
    - force s_stb_o=0 that cycle;
    - pulse mx_ack_o=1 with mx_dat_o=0;
    - set timeout_o=1 (cleared only by reset);
    - go to IDLE, last_gnt<=x.
  - A real s_ack_i in the same cycle wins: normal completion, no flag.
- Undefined: no counter, timeout_o tied 0, a transfer waits indefinitely.

Decomposition:
- Shared package cpu_bus_pkg:
  - state enum (IDLE/GNT0/GNT1);
  - constants ADR_W=32, DAT_W=32, SEL_W=4;
  - grant encodings GNT_NONE/GNT_M0/GNT_M1.
- One natural sub-module, bus_watchdog: counter plus sticky flag, instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- m0 read adr=0x00000010, slave acks 1 cycle after s_stb_o with dat=0xDEADBEEF -> m0_ack_o pulses once, m0_dat_o=0xDEADBEEF, m1_ack_o=0, gnt_o 01 then 00.
- Both request continuously, zero-wait slave, FIXED_PRIO=0 -> grants m0,m1,m0,m1 (first tie to m0), one transfer per 2 cycles.
- Same stimulus with FIXED_PRIO=1 -> m0 granted every time, m1 starved while m0_stb_i stays high.
- m1 write sel=4'b0011 dat=0x0000ABCD, slave waits 3 cycles -> s_* stable for 4 cycles, s_sel_o=0011, exactly one m1_ack_o.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never acks -> m0_ack_o at the 8th cycle of s_stb_o high, m0_dat_o=0, timeout_o=1 sticky. A later normal transfer completes.
- rst_ni low mid-wait in GNT1 -> s_stb_o and gnt_o 0 immediately; after release m0 wins the first tie.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the two-master CPU stb/ack bus arbiter.
// Imported by the interface, the arbiter top and the optional watchdog.
package cpu_bus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [1:0] gnt_decode(input arb_state_t st);
    logic [1:0] g;
    g = GNT_NONE;
    case (st)
      GNT0:    g = GNT_M0;
      GNT1:    g = GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side requests, slave-side bus and status signals of the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface bus_arbiter_if;
  import cpu_bus_pkg::*;

  logic             m0_stb_i;
  logic             m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic             m0_ack_o;
  logic [DAT_W-1:0] m0_dat_o;

  logic             m1_stb_i;
  logic             m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic             m1_ack_o;
  logic [DAT_W-1:0] m1_dat_o;

  logic             s_stb_o;
  logic             s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic [SEL_W-1:0] s_sel_o;
  logic             s_ack_i;
  logic [DAT_W-1:0] s_dat_i;

  logic [1:0]       gnt_o;
  logic             timeout_o;

  modport slave (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_ack_o, m0_dat_o,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_ack_o, m1_dat_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i,
    output gnt_o, timeout_o
  );

  modport master (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_ack_o, m0_dat_o,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_ack_o, m1_dat_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i,
    input  gnt_o, timeout_o
  );

endinterface

// File: rtl/bus_watchdog.sv
// Wait-cycle counter with sticky timeout flag; only instantiated when
// BUS_TIMEOUT_EN is defined. expire is a combinational one-cycle strike.
module bus_watchdog
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic busy,
  input  logic stb,
  input  logic ack,
  output logic expire,
  output logic timeout
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;

  // A real ack in the same cycle always beats the forced completion.
  assign expire = busy && stb && !ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      if (!busy) begin
        cnt_q <= '0;
      end else if (stb && !ack && !expire) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-slave stb/ack bus arbiter, round-robin or fixed priority.
// Define BUS_TIMEOUT_EN to add the wait-cycle watchdog and forced completion.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no grant; strobes sampled at the edge to choose the next owner
//  GNT0  | m0 owns the slave bus until ack, abort or timeout
//  GNT1  | m1 owns the slave bus until ack, abort or timeout
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst_ni,
  bus_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  arb_state_t state_q, state_d;
  logic       last_m1_q, last_m1_d;
  logic       expire;

`ifdef BUS_TIMEOUT_EN
  logic cur_stb;

  assign cur_stb = (state_q == GNT0) ? bus.m0_stb_i :
                   (state_q == GNT1) ? bus.m1_stb_i : 1'b0;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .busy    (state_q != IDLE),
    .stb     (cur_stb),
    .ack     (bus.s_ack_i),
    .expire  (expire),
    .timeout (bus.timeout_o)
  );
`else
  assign expire        = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // last_m1 resets high so that m0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_m1_d    = last_m1_q;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_dat_o = '0;

    case (state_q)
      IDLE: begin
        if (bus.m0_stb_i && bus.m1_stb_i) begin
          state_d = (FIXED_PRIO || last_m1_q) ? GNT0 : GNT1;
        end else if (bus.m0_stb_i) begin
          state_d = GNT0;
        end else if (bus.m1_stb_i) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        bus.s_stb_o  = bus.m0_stb_i && !expire;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        // An ack landing in the abort cycle belongs to nobody and is dropped.
        bus.m0_ack_o = (bus.m0_stb_i && bus.s_ack_i) || expire;
        if (bus.m0_stb_i && bus.s_ack_i) begin
          bus.m0_dat_o = bus.s_dat_i;
        end
        if (!bus.m0_stb_i || bus.s_ack_i || expire) begin
          state_d   = IDLE;
          last_m1_d = 1'b0;
        end
      end

      GNT1: begin
        bus.s_stb_o  = bus.m1_stb_i && !expire;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.m1_ack_o = (bus.m1_stb_i && bus.s_ack_i) || expire;
        if (bus.m1_stb_i && bus.s_ack_i) begin
          bus.m1_dat_o = bus.s_dat_i;
        end
        if (!bus.m1_stb_i || bus.s_ack_i || expire) begin
          state_d   = IDLE;
          last_m1_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt_o = gnt_decode(state_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: round-robin and fixed-priority
// instances, scoreboard of expected acks checked by a negedge monitor.
module tb_bus_arbiter;
  import cpu_bus_pkg::*;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic auto_ack = 1'b0;
  logic ack_drv = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  bus_arbiter_if bus();
  bus_arbiter_if bus_fp();

  bus_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_ni(rst_ni), .bus(bus)
  );

  bus_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .rst_ni(rst_ni), .bus(bus_fp)
  );

  // Slave model: zero-wait ack while granted, or scripted ack.
  assign bus.s_ack_i = auto_ack ? (bus.gnt_o != GNT_NONE) : ack_drv;

  // Fixed-priority instance sees the same masters and a zero-wait slave.
  assign bus_fp.m0_stb_i = bus.m0_stb_i;
  assign bus_fp.m0_we_i  = bus.m0_we_i;
  assign bus_fp.m0_adr_i = bus.m0_adr_i;
  assign bus_fp.m0_dat_i = bus.m0_dat_i;
  assign bus_fp.m0_sel_i = bus.m0_sel_i;
  assign bus_fp.m1_stb_i = bus.m1_stb_i;
  assign bus_fp.m1_we_i  = bus.m1_we_i;
  assign bus_fp.m1_adr_i = bus.m1_adr_i;
  assign bus_fp.m1_dat_i = bus.m1_dat_i;
  assign bus_fp.m1_sel_i = bus.m1_sel_i;
  assign bus_fp.s_dat_i  = bus.s_dat_i;
  assign bus_fp.s_ack_i  = (bus_fp.gnt_o != GNT_NONE);

  always @(negedge clk) begin
    if (bus.m0_ack_o || bus.m1_ack_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack=%b m0_dat=%h m1_dat=%h, required no ack",
                 {bus.m1_ack_o, bus.m0_ack_o}, bus.m0_dat_o, bus.m1_dat_o);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.m1_ack_o, bus.m0_ack_o, bus.m0_dat_o, bus.m1_dat_o} !==
            {mon_e.who, (mon_e.who == GNT_M0) ? mon_e.dat : 32'h0,
             (mon_e.who == GNT_M1) ? mon_e.dat : 32'h0}) begin
          errors++;
          $display("FAIL sb_ack: got ack=%b m0_dat=%h m1_dat=%h, required ack=%b dat=%h",
                   {bus.m1_ack_o, bus.m0_ack_o}, bus.m0_dat_o, bus.m1_dat_o,
                   mon_e.who, mon_e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ack(input logic [1:0] who, input logic [31:0] dat);
    exp_t e;
    e.who = who;
    e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_adr_i = '0;
    bus.m0_dat_i = '0;   bus.m0_sel_i = '0;
    bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_adr_i = '0;
    bus.m1_dat_i = '0;   bus.m1_sel_i = '0;
    bus.s_dat_i  = '0;
    ack_drv  = 1'b0;
    auto_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h1234; bus.m0_we_i = 1'b1;
    bus.m1_stb_i = 1'b1; bus.m1_sel_i = 4'hF;
    bus.s_dat_i = 32'h5555AAAA;
    ack_drv = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.gnt_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got gnt=%b stb=%b adr=%h, required all zero",
               bus.gnt_o, bus.s_stb_o, bus.s_adr_o);
    end
    checks++;
    if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o, bus.m1_dat_o, bus.timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_master: got acks=%b%b timeout=%b, required zero",
               bus.m0_ack_o, bus.m1_ack_o, bus.timeout_o);
    end
    bus.m0_stb_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ack_ignored: got gnt=%b acks=%b%b, required 0000",
               bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o);
    end
    ack_drv = 1'b0;
    bus.s_dat_i = '0;
  endtask

  task automatic test_single_read();
    bus.m0_adr_i = 32'h0000_0010;
    bus.m0_we_i  = 1'b0;
    bus.m0_sel_i = 4'hF;
    bus.m0_stb_i = 1'b1;
    expect_ack(GNT_M0, 32'hDEADBEEF);
    tick();
    checks++;
    if ({bus.gnt_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.m0_ack_o} !==
        {GNT_M0, 1'b1, 1'b0, 32'h0000_0010, 1'b0}) begin
      errors++;
      $display("FAIL read_grant: got gnt=%b stb=%b adr=%h ack=%b, required 01 1 00000010 0",
               bus.gnt_o, bus.s_stb_o, bus.s_adr_o, bus.m0_ack_o);
    end
    tick();
    ack_drv = 1'b1;
    bus.s_dat_i = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o} !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL read_ack: got acks=%b%b dat=%h, required 10 deadbeef",
               bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o);
    end
    tick();
    ack_drv = 1'b0;
    bus.m0_stb_i = 1'b0;
    bus.s_dat_i = '0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.m0_ack_o} !== 3'b000) begin
      errors++;
      $display("FAIL read_idle: got gnt=%b ack=%b, required 00 0", bus.gnt_o, bus.m0_ack_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL read_sb: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr, exp_fp;
    int fp_acks;
    fp_acks = 0;
    do_reset();
    bus.m0_adr_i = 32'h100; bus.m1_adr_i = 32'h200;
    bus.m0_sel_i = 4'hF;    bus.m1_sel_i = 4'hF;
    bus.s_dat_i  = 32'hCAFE0001;
    auto_ack = 1'b1;
    bus.m0_stb_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      expect_ack((c % 2 == 0) ? GNT_M0 : GNT_M1, 32'hCAFE0001);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_rr = (c % 2 == 1) ? GNT_NONE : (((c / 2) % 2 == 1) ? GNT_M1 : GNT_M0);
      exp_fp = (c % 2 == 1) ? GNT_NONE : GNT_M0;
      checks++;
      if (bus.gnt_o !== exp_rr) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b, required %b", c, bus.gnt_o, exp_rr);
      end
      checks++;
      if ({bus_fp.gnt_o, bus_fp.m1_ack_o} !== {exp_fp, 1'b0}) begin
        errors++;
        $display("FAIL fp_gnt[%0d]: got gnt=%b m1_ack=%b, required %b 0",
                 c, bus_fp.gnt_o, bus_fp.m1_ack_o, exp_fp);
      end
      if (bus_fp.m0_ack_o) fp_acks++;
      if (c == 7) begin
        bus.m0_stb_i = 1'b0;
        bus.m1_stb_i = 1'b0;
        auto_ack = 1'b0;
      end
    end
    tick();
    tick();
    checks++;
    if (fp_acks != 4) begin
      errors++;
      $display("FAIL fp_m0_acks: got %0d, required 4", fp_acks);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_sb: got %0d pending, required 0", sb.size());
    end
    bus.s_dat_i = '0;
  endtask

  task automatic test_wait_write();
    bus.m1_adr_i = 32'h40;
    bus.m1_we_i  = 1'b1;
    bus.m1_sel_i = 4'b0011;
    bus.m1_dat_i = 32'h0000ABCD;
    bus.s_dat_i  = '0;
    bus.m1_stb_i = 1'b1;
    expect_ack(GNT_M1, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) begin
        ack_drv = 1'b1;
        #1;
      end
      checks++;
      if ({bus.gnt_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o} !==
          {GNT_M1, 1'b1, 1'b1, 32'h40, 32'h0000ABCD, 4'b0011}) begin
        errors++;
        $display("FAIL wr_bus[%0d]: got gnt=%b stb=%b we=%b adr=%h dat=%h sel=%b, required 10 1 1 00000040 0000abcd 0011",
                 c, bus.gnt_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o);
      end
      checks++;
      if (bus.m1_ack_o !== (c == 3)) begin
        errors++;
        $display("FAIL wr_ack[%0d]: got %b, required %b", c, bus.m1_ack_o, (c == 3));
      end
    end
    tick();
    ack_drv = 1'b0;
    bus.m1_stb_i = 1'b0;
    bus.m1_we_i = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.s_stb_o, bus.m1_ack_o} !== 4'b0000) begin
      errors++;
      $display("FAIL wr_idle: got gnt=%b stb=%b ack=%b, required 00 0 0",
               bus.gnt_o, bus.s_stb_o, bus.m1_ack_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wr_sb: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_abort();
    bus.m0_adr_i = 32'h300;
    bus.m0_stb_i = 1'b1;
    bus.s_dat_i = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.gnt_o, bus.s_stb_o, bus.m0_ack_o} !== {GNT_M0, 2'b10}) begin
        errors++;
        $display("FAIL abort_wait[%0d]: got gnt=%b stb=%b ack=%b, required 01 1 0",
                 c, bus.gnt_o, bus.s_stb_o, bus.m0_ack_o);
      end
    end
    bus.m0_stb_i = 1'b0;
    ack_drv = 1'b1;
    #1;
    checks++;
    if ({bus.s_stb_o, bus.m0_ack_o, bus.m0_dat_o} !== '0) begin
      errors++;
      $display("FAIL abort_discard: got stb=%b ack=%b dat=%h, required 0 0 0",
               bus.s_stb_o, bus.m0_ack_o, bus.m0_dat_o);
    end
    tick();
    checks++;
    if ({bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got gnt=%b acks=%b%b, required 00 00",
               bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o);
    end
    ack_drv = 1'b0;
    bus.s_dat_i = '0;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    bus.m0_adr_i = 32'h80;
    bus.m0_stb_i = 1'b1;
    expect_ack(GNT_M0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (c < 7) begin
        if ({bus.s_stb_o, bus.m0_ack_o, bus.timeout_o} !== 3'b100) begin
          errors++;
          $display("FAIL to_wait[%0d]: got stb=%b ack=%b flag=%b, required 1 0 0",
                   c, bus.s_stb_o, bus.m0_ack_o, bus.timeout_o);
        end
      end else begin
        if ({bus.gnt_o, bus.s_stb_o, bus.m0_ack_o, bus.m0_dat_o} !== {GNT_M0, 2'b01, 32'h0}) begin
          errors++;
          $display("FAIL to_fire: got gnt=%b stb=%b ack=%b dat=%h, required 01 0 1 0",
                   bus.gnt_o, bus.s_stb_o, bus.m0_ack_o, bus.m0_dat_o);
        end
      end
    end
    bus.m0_stb_i = 1'b0;
    tick();
    checks++;
    if ({bus.gnt_o, bus.timeout_o} !== 3'b001) begin
      errors++;
      $display("FAIL to_flag: got gnt=%b flag=%b, required 00 1", bus.gnt_o, bus.timeout_o);
    end
    bus.m1_adr_i = 32'h500;
    bus.s_dat_i = 32'h5A5A0000;
    auto_ack = 1'b1;
    bus.m1_stb_i = 1'b1;
    expect_ack(GNT_M1, 32'h5A5A0000);
    tick();
    checks++;
    if ({bus.gnt_o, bus.m1_ack_o} !== {GNT_M1, 1'b1}) begin
      errors++;
      $display("FAIL to_after: got gnt=%b ack=%b, required 10 1", bus.gnt_o, bus.m1_ack_o);
    end
    tick();
    bus.m1_stb_i = 1'b0;
    auto_ack = 1'b0;
    bus.s_dat_i = '0;
    tick();
    checks++;
    if ({bus.timeout_o, bus.gnt_o} !== 3'b100) begin
      errors++;
      $display("FAIL to_sticky: got flag=%b gnt=%b, required 1 00", bus.timeout_o, bus.gnt_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL to_sb: got %0d pending, required 0", sb.size());
    end
  endtask
`else
  task automatic test_no_timeout();
    bus.m0_adr_i = 32'h80;
    bus.m0_stb_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({bus.gnt_o, bus.s_stb_o, bus.m0_ack_o, bus.timeout_o} !== {GNT_M0, 3'b100}) begin
        errors++;
        $display("FAIL nto_wait[%0d]: got gnt=%b stb=%b ack=%b flag=%b, required 01 1 0 0",
                 c, bus.gnt_o, bus.s_stb_o, bus.m0_ack_o, bus.timeout_o);
      end
    end
    bus.m0_stb_i = 1'b0;
    tick();
    checks++;
    if ({bus.gnt_o, bus.timeout_o} !== 3'b000) begin
      errors++;
      $display("FAIL nto_idle: got gnt=%b flag=%b, required 00 0", bus.gnt_o, bus.timeout_o);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus.m1_adr_i = 32'h600;
    bus.m1_stb_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.gnt_o, bus.s_stb_o} !== {GNT_M1, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_pre: got gnt=%b stb=%b, required 10 1", bus.gnt_o, bus.s_stb_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.s_stb_o, bus.m1_ack_o, bus.s_adr_o, bus.timeout_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got gnt=%b stb=%b ack=%b adr=%h flag=%b, required zero",
               bus.gnt_o, bus.s_stb_o, bus.m1_ack_o, bus.s_adr_o, bus.timeout_o);
    end
    bus.m0_adr_i = 32'h700;
    bus.m0_stb_i = 1'b1;
    bus.s_dat_i = 32'h11110000;
    auto_ack = 1'b1;
    tick();
    rst_ni = 1'b1;
    expect_ack(GNT_M0, 32'h11110000);
    tick();
    checks++;
    if ({bus.gnt_o, bus.m0_ack_o} !== {GNT_M0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_tie: got gnt=%b ack=%b, required 01 1", bus.gnt_o, bus.m0_ack_o);
    end
    tick();
    bus.m0_stb_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    auto_ack = 1'b0;
    #1;
    checks++;
    if (bus.gnt_o !== GNT_NONE) begin
      errors++;
      $display("FAIL rstmid_idle: got gnt=%b, required 00", bus.gnt_o);
    end
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_sb: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t, required finish", $time);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_write();
    test_abort();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
